// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 register file.
//   - CP0 register numbers (sel 0)
//   - exception codes
//   - field bit positions and read masks
//   - helpers classifying which exception codes load BadVAddr / EntryHi
package cp0_pkg;

  localparam logic [4:0] INDEX    = 5'd0;
  localparam logic [4:0] ENTRYLO0 = 5'd2;
  localparam logic [4:0] ENTRYLO1 = 5'd3;
  localparam logic [4:0] BADVADDR = 5'd8;
  localparam logic [4:0] COUNT    = 5'd9;
  localparam logic [4:0] ENTRYHI  = 5'd10;
  localparam logic [4:0] COMPARE  = 5'd11;
  localparam logic [4:0] STATUS   = 5'd12;
  localparam logic [4:0] CAUSE    = 5'd13;
  localparam logic [4:0] EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status fields
  localparam int unsigned STATUS_BEV = 22;
  localparam int unsigned STATUS_IM  = 8;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned STATUS_IE  = 0;
  // Cause fields
  localparam int unsigned CAUSE_BD   = 31;
  localparam int unsigned CAUSE_TI   = 30;
  localparam int unsigned CAUSE_IP   = 8;
  localparam int unsigned CAUSE_EXC  = 2;
  // Index.P
  localparam int unsigned INDEX_P    = 31;

  localparam logic [31:0] ENTRYHI_MASK = 32'hFFFF_E0FF;
  localparam logic [31:0] ENTRYLO_MASK = 32'h03FF_FFFF;

  function automatic logic is_tlb_exc(input logic [4:0] code);
    return (code == EXC_MOD) || (code == EXC_TLBL) || (code == EXC_TLBS);
  endfunction

  function automatic logic loads_badvaddr(input logic [4:0] code);
    return is_tlb_exc(code) || (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with prescaler and timer-interrupt flag.
//   clk, reset     : clock, synchronous active-high reset
//   count_we       : load Count from wdata, restart prescaler
//   compare_we     : load Compare from wdata, clear TI
//   wdata          : write data
//   count, compare : register values
//   ti             : timer interrupt pending
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_inc;

  assign tick      = (presc == PRESC_LAST);
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        presc <= '0;
      end else if (tick) begin
        count <= count_inc;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      // TI fires when Count steps onto Compare, so the all-zero state
      // after reset does not raise a spurious timer interrupt.
      if (compare_we)
        ti <= 1'b0;
      else if (tick && !count_we && (count_inc == compare))
        ti <= 1'b1;

      if (compare_we)
        compare <= wdata;
    end
  end

endmodule

// File: rtl/cp0_tlb.sv
// cp0_tlb: CP0 register file with TLB support (Index, EntryHi, EntryLo0/1,
// TLBP/TLBR side effects, TLB exception side effects).
//   reg_num/sel/reg_in/wen : mtc0 access; reg_out is combinational read data
//   exception/eret/...     : exception and eret commit from writeback
//   interrupt              : hardware interrupt lines -> Cause.IP[2+k]
//   tlbp*/tlbr*            : TLB instruction commit and results
//   epc_out, entryhi_out, entrylo0_out, entrylo1_out, index_out : to fetch/TLB
//   int_pending, exception_now, eret_now : combinational status
module cp0_tlb
  import cp0_pkg::*;
#(
  parameter int unsigned TLBNUM       = 16,
  parameter int unsigned TLBNUM_WIDTH = $clog2(TLBNUM),
  parameter int unsigned COUNT_DIV    = 2,
  parameter int unsigned HW_INT_NUM   = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              reg_num,
  input  logic [2:0]              sel,
  input  logic [31:0]             reg_in,
  input  logic                    wen,
  input  logic                    exception,
  input  logic                    eret,
  input  logic [4:0]              exccode,
  input  logic                    is_delay_slot,
  input  logic [31:0]             pc,
  input  logic [31:0]             badvaddr_in,
  input  logic [HW_INT_NUM-1:0]   interrupt,
  input  logic                    tlbp,
  input  logic                    tlbp_found,
  input  logic [TLBNUM_WIDTH-1:0] tlbp_index,
  input  logic                    tlbr,
  input  logic [31:0]             tlbr_entryhi,
  input  logic [31:0]             tlbr_entrylo0,
  input  logic [31:0]             tlbr_entrylo1,
  output logic [31:0]             reg_out,
  output logic [31:0]             epc_out,
  output logic [31:0]             entryhi_out,
  output logic [31:0]             entrylo0_out,
  output logic [31:0]             entrylo1_out,
  output logic [TLBNUM_WIDTH-1:0] index_out,
  output logic                    int_pending,
  output logic                    exception_now,
  output logic                    eret_now
);

  logic [7:0]              status_im;
  logic                    status_exl;
  logic                    status_ie;
  logic                    cause_bd;
  logic [7:0]              cause_ip;
  logic [4:0]              cause_exc;
  logic [31:0]             epc_q;
  logic [31:0]             badvaddr_q;
  logic [31:0]             entryhi_q;
  logic [31:0]             entrylo0_q;
  logic [31:0]             entrylo1_q;
  logic                    index_p;
  logic [TLBNUM_WIDTH-1:0] index_q;

  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  hw_int;
  logic        wr;
  logic [31:0] status_rd, cause_rd, index_rd;

  // mtc0 is the lowest-priority event; sel != 0 is unimplemented.
  assign wr = wen && (sel == 3'd0) && !(eret || exception || tlbp || tlbr);

  assign exception_now = exception && !status_exl;
  assign eret_now      = eret;

  // Zero-extend to six lines; the timer shares IP[7] with line 5.
  always_comb begin
    hw_int    = 6'(interrupt);
    hw_int[5] = hw_int[5] | ti;
  end

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr && (reg_num == COUNT)),
    .compare_we (wr && (reg_num == COMPARE)),
    .wdata      (reg_in),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
      cause_bd   <= 1'b0;
      cause_ip   <= '0;
      cause_exc  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      entryhi_q  <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      index_p    <= 1'b0;
      index_q    <= '0;
    end else begin
      cause_ip[7:2] <= hw_int;

      if (eret) begin
        status_exl <= 1'b0;
      end else if (exception) begin
        status_exl <= 1'b1;
        cause_exc  <= exccode;
        if (!status_exl) begin
          cause_bd <= is_delay_slot;
          epc_q    <= is_delay_slot ? (pc - 32'd4) : pc;
        end
        if (loads_badvaddr(exccode))
          badvaddr_q <= badvaddr_in;
        if (is_tlb_exc(exccode))
          entryhi_q[31:13] <= badvaddr_in[31:13];
      end else if (tlbp) begin
        index_p <= !tlbp_found;
        if (tlbp_found)
          index_q <= tlbp_index;
      end else if (tlbr) begin
        entryhi_q  <= tlbr_entryhi & ENTRYHI_MASK;
        entrylo0_q <= tlbr_entrylo0 & ENTRYLO_MASK;
        entrylo1_q <= tlbr_entrylo1 & ENTRYLO_MASK;
      end else if (wr) begin
        case (reg_num)
          STATUS: begin
            status_im  <= reg_in[STATUS_IM +: 8];
            status_exl <= reg_in[STATUS_EXL];
            status_ie  <= reg_in[STATUS_IE];
          end
          CAUSE:    cause_ip[1:0] <= reg_in[CAUSE_IP +: 2];
          EPC:      epc_q         <= reg_in;
          ENTRYHI:  entryhi_q     <= reg_in & ENTRYHI_MASK;
          ENTRYLO0: entrylo0_q    <= reg_in & ENTRYLO_MASK;
          ENTRYLO1: entrylo1_q    <= reg_in & ENTRYLO_MASK;
          INDEX:    index_q       <= reg_in[TLBNUM_WIDTH-1:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    status_rd                    = '0;
    status_rd[STATUS_BEV]        = 1'b1;
    status_rd[STATUS_IM +: 8]    = status_im;
    status_rd[STATUS_EXL]        = status_exl;
    status_rd[STATUS_IE]         = status_ie;

    cause_rd                     = '0;
    cause_rd[CAUSE_BD]           = cause_bd;
    cause_rd[CAUSE_TI]           = ti;
    cause_rd[CAUSE_IP +: 8]      = cause_ip;
    cause_rd[CAUSE_EXC +: 5]     = cause_exc;

    index_rd                     = '0;
    index_rd[INDEX_P]            = index_p;
    index_rd[TLBNUM_WIDTH-1:0]   = index_q;
  end

  always_comb begin
    reg_out = '0;
    if (sel == 3'd0) begin
      case (reg_num)
        INDEX:    reg_out = index_rd;
        ENTRYLO0: reg_out = entrylo0_q;
        ENTRYLO1: reg_out = entrylo1_q;
        BADVADDR: reg_out = badvaddr_q;
        COUNT:    reg_out = count;
        ENTRYHI:  reg_out = entryhi_q;
        COMPARE:  reg_out = compare;
        STATUS:   reg_out = status_rd;
        CAUSE:    reg_out = cause_rd;
        EPC:      reg_out = epc_q;
        default:  reg_out = '0;
      endcase
    end
  end

  assign epc_out      = epc_q;
  assign entryhi_out  = entryhi_q;
  assign entrylo0_out = entrylo0_q;
  assign entrylo1_out = entrylo1_q;
  assign index_out    = index_q;
  assign int_pending  = status_ie && !status_exl && |(cause_ip & status_im);

endmodule

// File: tb/tb_cp0_tlb.sv
`timescale 1ns/1ps
module tb_cp0_tlb;
  import cp0_pkg::*;

  localparam int unsigned TLBNUM_WIDTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  reg_num;
  logic [2:0]  sel;
  logic [31:0] reg_in;
  logic        wen, exception, eret, is_delay_slot;
  logic [4:0]  exccode;
  logic [31:0] pc, badvaddr_in;
  logic [5:0]  interrupt;
  logic        tlbp, tlbp_found, tlbr;
  logic [TLBNUM_WIDTH-1:0] tlbp_index;
  logic [31:0] tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1;
  logic [31:0] reg_out, epc_out, entryhi_out, entrylo0_out, entrylo1_out;
  logic [TLBNUM_WIDTH-1:0] index_out;
  logic        int_pending, exception_now, eret_now;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  cp0_tlb #(.TLBNUM(16), .COUNT_DIV(2), .HW_INT_NUM(6)) dut (
    .clk(clk), .reset(reset), .reg_num(reg_num), .sel(sel), .reg_in(reg_in),
    .wen(wen), .exception(exception), .eret(eret), .exccode(exccode),
    .is_delay_slot(is_delay_slot), .pc(pc), .badvaddr_in(badvaddr_in),
    .interrupt(interrupt), .tlbp(tlbp), .tlbp_found(tlbp_found),
    .tlbp_index(tlbp_index), .tlbr(tlbr), .tlbr_entryhi(tlbr_entryhi),
    .tlbr_entrylo0(tlbr_entrylo0), .tlbr_entrylo1(tlbr_entrylo1),
    .reg_out(reg_out), .epc_out(epc_out), .entryhi_out(entryhi_out),
    .entrylo0_out(entrylo0_out), .entrylo1_out(entrylo1_out),
    .index_out(index_out), .int_pending(int_pending),
    .exception_now(exception_now), .eret_now(eret_now)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    reg_num = r;
    sel = 3'd0;
    #1;
    check(tag, reg_out, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] v);
    reg_num = r; sel = 3'd0; reg_in = v; wen = 1'b1;
    step();
    wen = 1'b0;
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] p, input logic ds,
                       input logic [31:0] bad, input logic exp_now);
    exception = 1'b1; exccode = code; pc = p; is_delay_slot = ds; badvaddr_in = bad;
    #1;
    check("exception_now", {31'b0, exception_now}, {31'b0, exp_now});
    step();
    exception = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; reg_num = '0; sel = '0; reg_in = '0; wen = 1'b0;
    exception = 1'b0; eret = 1'b0; exccode = '0; is_delay_slot = 1'b0;
    pc = '0; badvaddr_in = '0; interrupt = '0; tlbp = 1'b0; tlbp_found = 1'b0;
    tlbp_index = '0; tlbr = 1'b0; tlbr_entryhi = '0; tlbr_entrylo0 = '0;
    tlbr_entrylo1 = '0;
    step(); step(); step();
    reset = 1'b0;

    // 1. reset state
    chk_reg("rst_status", STATUS, 32'h0040_0000);
    chk_reg("rst_cause",  CAUSE,  32'h0);
    chk_reg("rst_count",  COUNT,  32'h0);
    chk_reg("rst_index",  INDEX,  32'h0);
    check("rst_epc_out", epc_out, 32'h0);
    check("rst_int_pending", {31'b0, int_pending}, 32'h0);

    // 2. timer interrupt: Count=0 then Compare=20 -> IP7 visible 40 edges later
    mtc0(STATUS, 32'h0000_8001);
    mtc0(COUNT, 32'h0);
    mtc0(COMPARE, 32'd20);
    n = 0;
    while (!int_pending && n < 100) begin
      step();
      n++;
    end
    check("ti_latency", n, 32'd40);
    chk_reg("ti_count", COUNT, 32'd20);
    chk_reg("ti_cause", CAUSE, 32'h4000_8000);
    mtc0(COMPARE, 32'd1000);
    chk_reg("ti_clear", CAUSE, 32'h0000_8000);
    step();
    check("ti_int_clear", {31'b0, int_pending}, 32'h0);
    mtc0(STATUS, 32'h0);

    // Count wrap
    mtc0(COUNT, 32'hFFFF_FFFF);
    step(); step();
    chk_reg("count_wrap", COUNT, 32'h0);

    // 3. TLBL exception in delay slot
    mtc0(ENTRYHI, 32'h0000_00A5);
    raise(EXC_TLBL, 32'h8000_1004, 1'b1, 32'h0040_2ABC, 1'b1);
    chk_reg("exc_epc",      EPC,      32'h8000_1000);
    chk_reg("exc_cause",    CAUSE,    32'h8000_0008);
    chk_reg("exc_badvaddr", BADVADDR, 32'h0040_2ABC);
    chk_reg("exc_entryhi",  ENTRYHI,  32'h0040_20A5);
    chk_reg("exc_status",   STATUS,   32'h0040_0002);
    check("exc_epc_out", epc_out, 32'h8000_1000);

    // 4. nested exception while EXL=1, then eret
    raise(EXC_ADEL, 32'h9000_0000, 1'b0, 32'h0000_1234, 1'b0);
    chk_reg("nest_epc",      EPC,      32'h8000_1000);
    chk_reg("nest_cause",    CAUSE,    32'h8000_0010);
    chk_reg("nest_badvaddr", BADVADDR, 32'h0000_1234);
    chk_reg("nest_entryhi",  ENTRYHI,  32'h0040_20A5);
    eret = 1'b1;
    #1;
    check("eret_now", {31'b0, eret_now}, 32'h1);
    step();
    eret = 1'b0;
    chk_reg("eret_status", STATUS, 32'h0040_0000);

    // hardware interrupt line 2 -> IP4
    interrupt = 6'b000100;
    step();
    chk_reg("hw_cause", CAUSE, 32'h8000_1010);
    mtc0(STATUS, 32'h0000_1001);
    check("hw_int_pending", {31'b0, int_pending}, 32'h1);
    interrupt = '0;
    step();
    check("hw_int_clear", {31'b0, int_pending}, 32'h0);
    mtc0(STATUS, 32'h0);

    // 5. Index: mtc0 cannot set P; tlbp miss/hit
    mtc0(INDEX, 32'hFFFF_FFF3);
    chk_reg("index_wr", INDEX, 32'h0000_0003);
    tlbp = 1'b1; tlbp_found = 1'b0; tlbp_index = 4'd9;
    step();
    chk_reg("tlbp_miss", INDEX, 32'h8000_0003);
    tlbp_found = 1'b1; tlbp_index = 4'd5;
    step();
    tlbp = 1'b0;
    chk_reg("tlbp_hit", INDEX, 32'h0000_0005);
    check("index_out", {28'b0, index_out}, 32'h5);

    // 6. tlbr (with a competing mtc0 that must lose), EntryLo masks
    tlbr = 1'b1; tlbr_entryhi = 32'hABCD_E0FF;
    tlbr_entrylo0 = 32'h03FF_FFFF; tlbr_entrylo1 = 32'hFFFF_FFFF;
    wen = 1'b1; reg_num = ENTRYLO0; reg_in = 32'h0;
    step();
    tlbr = 1'b0; wen = 1'b0;
    chk_reg("tlbr_entryhi", ENTRYHI, 32'hABCD_E0FF);
    chk_reg("tlbr_lo0",     ENTRYLO0, 32'h03FF_FFFF);
    chk_reg("tlbr_lo1",     ENTRYLO1, 32'h03FF_FFFF);
    mtc0(ENTRYLO1, 32'h1234_5678);
    chk_reg("lo1_mask", ENTRYLO1, 32'h0234_5678);
    mtc0(ENTRYLO1, 32'hFFFF_FFFF);
    chk_reg("lo1_ones", ENTRYLO1, 32'h03FF_FFFF);
    check("lo1_out", entrylo1_out, 32'h03FF_FFFF);
    mtc0(ENTRYHI, 32'hFFFF_FFFF);
    check("entryhi_mask", entryhi_out, 32'hFFFF_E0FF);

    // sel != 0 ignored and reads 0; EPC writable
    reg_num = STATUS; sel = 3'd1; reg_in = 32'h0000_0003; wen = 1'b1;
    #1;
    check("sel1_read", reg_out, 32'h0);
    step();
    wen = 1'b0;
    chk_reg("sel1_nowrite", STATUS, 32'h0040_0000);
    mtc0(EPC, 32'hBFC0_0380);
    chk_reg("epc_wr", EPC, 32'hBFC0_0380);

    // 7. reset overrides a same-cycle exception
    reset = 1'b1; exception = 1'b1; exccode = EXC_TLBS; pc = 32'h1234_5678;
    badvaddr_in = 32'hFFFF_FFFF;
    step();
    reset = 1'b0; exception = 1'b0;
    chk_reg("rst2_status", STATUS, 32'h0040_0000);
    chk_reg("rst2_epc",    EPC,    32'h0);
    chk_reg("rst2_bad",    BADVADDR, 32'h0);
    check("rst2_entryhi", entryhi_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
